uart_imem_loader: RTL and testbench
===================================

# uart_imem_loader

Writable 32 x 16 instruction memory that is filled from a host over a UART serial line (8N1, LSB first) and read asynchronously by the processor's fetch path in place of the fixed instruction ROM. The block receives bytes, pairs them into 16-bit instruction words (high byte first) and writes them to consecutive addresses starting at 0. It sits at the FPGA top next to the PC and selector: the host loads the program, the user presses reset and the processor fetches it.

## Interface
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 4
- DEPTH, 32, instruction words held
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W
- clk  input  1  system clock
- reset  input  1  synchronous, active-high; clears receiver, pointers and flags, but not memory contents
- rx  input  1  UART serial line, idle high, asynchronous to clk
- enable  input  1  1 = accept loaded words; 0 = receive and discard
- read_addr  input  ADDR_W  fetch address from the PC
- read_data  output  16  mem[read_addr], combinational
- load_count  output  ADDR_W+1  words written since reset, 0..DEPTH
- half  output  1  high byte of the current word held, low byte pending
- full  output  1  load_count == DEPTH
- word_wr  output  1  one-cycle pulse on each memory write
- frame_err  output  1  sticky; set on a bad stop bit

## Operation
- rx passes through a 2-flop synchronizer; the FSM only sees rx_s.
- Receiver FSM states, with a bit-timer and a 3-bit bit index:
  - WAIT_IDLE: entered at reset. Go to IDLE once rx_s is 1.
  - IDLE: a 0 on rx_s moves to START and loads the timer.
  - START: at CLKS_PER_BIT/2 cycles, rx_s = 0 moves to DATA; rx_s = 1 is a glitch and returns to IDLE.
  - DATA: sample rx_s every CLKS_PER_BIT cycles, 8 bits, LSB first. After bit 7 go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles. rx_s = 1 gives byte_valid for 1 cycle and moves to IDLE. rx_s = 0 sets frame_err, drops the byte and moves to WAIT_IDLE.
- Byte assembly on byte_valid:
  - enable = 0 or full = 1: discard the byte and clear half.
  - half = 0: latch the byte as hi and set half.
  - half = 1: write {hi, byte} to mem[wr_addr], pulse word_wr, increment wr_addr and load_count, clear half.
- wr_addr equals load_count[ADDR_W-1:0]. There is no wrap-around: once full, every byte is discarded until reset.
- A frame error does not disturb half or hi; the next good byte continues the word.
- Memory is initialised to 0 at configuration. reset does not clear memory contents.
- Reset mid-frame aborts the byte and enters WAIT_IDLE, so a frame already in progress is never misparsed.
- Reset during the same cycle as byte_valid: reset wins and nothing is written.
- Deasserting enable mid-word clears half only when the next byte arrives. The bytes of a word are either both accepted or both dropped.

## Timing
- Reset values: half 0, full 0, load_count 0, word_wr 0, frame_err 0, FSM WAIT_IDLE.
- Synchronizer latency is 2 cycles.
- byte_valid fires about (9.5 x CLKS_PER_BIT + 2) cycles after the falling edge of the start bit on rx.
- The memory write, word_wr pulse and load_count increment take effect on the clock edge after byte_valid (1 cycle).
- read_data shows the new word combinationally from that edge.
- full rises in the same cycle that load_count reaches DEPTH.
- frame_err rises 1 cycle after the bad stop sample and holds until reset.
- Back-to-back frames are supported: the next start bit may follow the stop bit immediately.

## Test plan
All scenarios use CLKS_PER_BIT = 4.
- Reset, then send 0x12, 0x34 with enable = 1 -> exactly one word_wr pulse; mem[0] = 0x1234; load_count = 1; half = 0; read_addr = 0 gives read_data = 0x1234.
- Send 64 bytes forming words 0x0000..0x001F, then 2 more bytes -> full = 1 after the 32nd word; load_count = 32; no 33rd word_wr; mem[31] = 0x001F; mem[0] unchanged.
- Frame with stop bit = 0 after byte 0xAB -> frame_err = 1; no write; half unchanged. A following good pair 0x56, 0x78 writes 0x5678.
- A 1-cycle low glitch on rx while idle -> FSM returns to IDLE; no byte_valid; frame_err stays 0.
- enable = 0 while sending 0xDE, 0xAD -> no word_wr; load_count = 0; half = 0. Then enable = 1 and send 0xBE, 0xEF -> mem[0] = 0xBEEF.
- Assert reset during the DATA bits of a frame -> load_count = 0; half = 0; frame_err = 0; the rest of that frame is ignored. The next full frame pair is written to address 0.

Source files
------------

// File: rtl/uart_imem_loader.sv
// Writable 32x16 instruction memory loaded over a UART line (8N1, LSB first).
// Byte pairs form words (high byte first) written to consecutive addresses from 0.
module uart_imem_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 32,
    parameter int ADDR_W       = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic              enable,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [15:0]       read_data,
    output logic [ADDR_W:0]   load_count,
    output logic              half,
    output logic              full,
    output logic              word_wr,
    output logic              frame_err,
    output logic [2:0]        rx_state
);

    // Handshake: byte_valid is a one-cycle pulse with the received byte in
    // rx_byte; there is no back-pressure, each pulse is consumed that cycle.

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } rx_state_t;

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_T = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_T = TW'(CLKS_PER_BIT - 1);

    rx_state_t         state, state_n;
    logic              rx_meta, rx_s;
    logic [TW-1:0]     timer;
    logic [2:0]        bit_idx;
    logic [7:0]        rx_byte;
    logic              byte_valid;
    logic              timer_clr, shift_en, bit_clr, byte_done, frame_set;
    logic [7:0]        hi;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       mem [DEPTH] = '{default: 16'h0000};

    assign rx_state = state;

    // Synchronizer resets low so WAIT_IDLE only leaves on a real idle line.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b0;
            rx_s    <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= WAIT_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        timer_clr = 1'b0;
        shift_en  = 1'b0;
        bit_clr   = 1'b0;
        byte_done = 1'b0;
        frame_set = 1'b0;
        case (state)
            WAIT_IDLE: begin
                timer_clr = 1'b1;
                if (rx_s) state_n = IDLE;
            end
            IDLE: begin
                timer_clr = 1'b1;
                bit_clr   = 1'b1;
                if (!rx_s) state_n = START;
            end
            START: begin
                // Mid-start-bit check rejects short glitches on the line.
                if (timer == HALF_T) begin
                    timer_clr = 1'b1;
                    state_n   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer == FULL_T) begin
                    timer_clr = 1'b1;
                    shift_en  = 1'b1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (timer == FULL_T) begin
                    timer_clr = 1'b1;
                    if (rx_s) begin
                        byte_done = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_n   = WAIT_IDLE;
                    end
                end
            end
            default: state_n = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer      <= '0;
            bit_idx    <= 3'd0;
            rx_byte    <= 8'h00;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            timer <= timer_clr ? '0 : timer + 1'b1;
            if (bit_clr)
                bit_idx <= 3'd0;
            else if (shift_en)
                bit_idx <= bit_idx + 3'd1;
            if (shift_en)
                rx_byte <= {rx_s, rx_byte[7:1]};
            byte_valid <= byte_done;
            if (frame_set)
                frame_err <= 1'b1;
        end
    end

    assign full    = (load_count == (ADDR_W + 1)'(DEPTH));
    assign wr_addr = load_count[ADDR_W-1:0];
    assign wr_en   = byte_valid & enable & ~full & half & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            half       <= 1'b0;
            hi         <= 8'h00;
            load_count <= '0;
            word_wr    <= 1'b0;
        end else begin
            word_wr <= 1'b0;
            if (byte_valid) begin
                // Dropping a byte also drops any pending high byte, so a word is all-or-nothing.
                if (!enable || full) begin
                    half <= 1'b0;
                end else if (!half) begin
                    hi   <= rx_byte;
                    half <= 1'b1;
                end else begin
                    load_count <= load_count + 1'b1;
                    half       <= 1'b0;
                    word_wr    <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= {hi, rx_byte};
    end

    assign read_data = mem[read_addr];

endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: serial driver, word-level reference model,
// and a write monitor that pops expected words from a queue.
module tb_uart_imem_loader;

    localparam int CPB   = 4;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk;
    logic          reset;
    logic          rx;
    logic          enable;
    logic [AW-1:0] read_addr;
    logic [15:0]   read_data;
    logic [AW:0]   load_count;
    logic          half;
    logic          full;
    logic          word_wr;
    logic          frame_err;
    logic [2:0]    rx_state;

    uart_imem_loader #(
        .CLKS_PER_BIT(CPB),
        .DEPTH(DEPTH),
        .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .enable(enable),
        .read_addr(read_addr),
        .read_data(read_data),
        .load_count(load_count),
        .half(half),
        .full(full),
        .word_wr(word_wr),
        .frame_err(frame_err),
        .rx_state(rx_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // expected writes: {load_count after write, word}
    logic [21:0] exp_q[$];

    // reference model of the loader at word level
    bit          m_half;
    logic [7:0]  m_hi;
    int          m_count;
    bit          m_ferr;
    logic [15:0] m_mem [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_half  = 1'b0;
        m_count = 0;
        m_ferr  = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] d, input bit good);
        logic [15:0] w;
        if (!good) begin
            m_ferr = 1'b1;
            return;
        end
        if (!enable || m_count == DEPTH) begin
            m_half = 1'b0;
        end else if (!m_half) begin
            m_hi   = d;
            m_half = 1'b1;
        end else begin
            w = {m_hi, d};
            m_mem[m_count] = w;
            read_addr = AW'(m_count);
            m_count++;
            exp_q.push_back({6'(m_count), w});
            m_half = 1'b0;
        end
    endtask

    // driver tasks; all start and end at posedge + 1
    task automatic hold_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        idle_cycles(6);
    endtask

    // rst_bit >= 0 pulses reset during that data bit and abandons the frame
    task automatic send_byte(input logic [7:0] d, input bit stop_ok, input int rst_bit);
        bit aborted;
        aborted = 1'b0;
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == rst_bit) begin
                rx    = d[i];
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                model_reset();
                aborted = 1'b1;
                repeat (CPB - 1) @(posedge clk);
                #1;
            end else begin
                hold_bit(d[i]);
            end
        end
        hold_bit(stop_ok);
        if (!aborted) model_byte(d, stop_ok);
        idle_cycles(4 + $urandom_range(0, 6));
    endtask

    task automatic glitch();
        rx = 1'b0;
        @(posedge clk);
        #1;
        idle_cycles(12);
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        check({tag, "_half"}, 32'(half), 32'(m_half));
        check({tag, "_count"}, 32'(load_count), 32'(m_count));
        check({tag, "_ferr"}, 32'(frame_err), 32'(m_ferr));
        check({tag, "_full"}, 32'(full), 32'(m_count == DEPTH));
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (word_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word_wr: got write of %0h at count %0d expected none", read_data, load_count);
            end else begin
                logic [21:0] e;
                e = exp_q.pop_front();
                check("wr_count", 32'(load_count), 32'(e[21:16]));
                check("wr_data", 32'(read_data), 32'(e[15:0]));
                check("wr_full", 32'(full), 32'(e[21:16] == 6'(DEPTH)));
            end
        end
    end

    initial begin
        logic [7:0] b;
        rx        = 1'b1;
        reset     = 1'b1;
        enable    = 1'b1;
        read_addr = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        check("rst_half", 32'(half), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(load_count), 32'd0);
        check("rst_word_wr", 32'(word_wr), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        @(posedge clk);
        #1;
        idle_cycles(6);

        // basic word
        send_byte(8'h12, 1'b1, -1);
        send_byte(8'h34, 1'b1, -1);
        check_state("basic");
        read_addr = 0;
        #1;
        check("basic_mem0", 32'(read_data), 32'h1234);

        // frame error, then a good pair; then an error between the two halves
        do_reset();
        send_byte(8'hAB, 1'b0, -1);
        check_state("ferr");
        send_byte(8'h56, 1'b1, -1);
        send_byte(8'h78, 1'b1, -1);
        send_byte(8'h9A, 1'b1, -1);
        send_byte(8'hC3, 1'b0, -1);
        check_state("ferr_mid");
        send_byte(8'hBC, 1'b1, -1);
        check_state("ferr_after");

        // glitch while idle with a high byte pending
        do_reset();
        send_byte(8'h11, 1'b1, -1);
        glitch();
        check_state("glitch");
        send_byte(8'h22, 1'b1, -1);
        check_state("glitch_after");

        // enable low discards; enable dropped mid-word clears half
        do_reset();
        enable = 1'b0;
        send_byte(8'hDE, 1'b1, -1);
        send_byte(8'hAD, 1'b1, -1);
        check_state("dis");
        enable = 1'b1;
        send_byte(8'hBE, 1'b1, -1);
        send_byte(8'hEF, 1'b1, -1);
        read_addr = 0;
        #1;
        check("dis_mem0", 32'(read_data), 32'hBEEF);
        send_byte(8'h01, 1'b1, -1);
        enable = 1'b0;
        send_byte(8'h02, 1'b1, -1);
        check_state("dis_mid");
        enable = 1'b1;
        send_byte(8'h03, 1'b1, -1);
        send_byte(8'h04, 1'b1, -1);
        check_state("dis_after");

        // reset in the middle of a frame's data bits
        do_reset();
        send_byte(8'h77, 1'b1, -1);
        send_byte(8'h00, 1'b1, 3);
        check_state("midrst");
        send_byte(8'($urandom), 1'b1, -1);
        send_byte(8'($urandom), 1'b1, -1);
        check_state("midrst_after");

        // randomized traffic
        for (int n = 0; n < 30; n++) begin
            enable = ($urandom_range(0, 5) != 0);
            b = 8'($urandom);
            send_byte(b, ($urandom_range(0, 7) != 0), -1);
            if (n % 3 == 2) check_state("rand");
        end

        // fill to DEPTH, then overflow bytes are discarded
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            send_byte(8'h00, 1'b1, -1);
            send_byte(8'(i), 1'b1, -1);
        end
        check_state("fill");
        send_byte(8'($urandom), 1'b1, -1);
        send_byte(8'($urandom), 1'b1, -1);
        check_state("fill_over");
        for (int i = 0; i < DEPTH; i++) begin
            read_addr = AW'(i);
            #1;
            check("readback", 32'(read_data), 32'(m_mem[i]));
        end
        read_addr = 0;
        #1;
        check("fill_mem0", 32'(read_data), 32'h0000);
        read_addr = AW'(DEPTH - 1);
        #1;
        check("fill_mem31", 32'(read_data), 32'h001F);

        idle_cycles(20);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
